// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller and its helpers.
package hazard_pkg;

    // Register index that is hard-wired to zero and therefore never forwarded.
    localparam int unsigned REG_ZERO = 0;

    // Operand-select encodings for the E-stage ALU input muxes.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // Data-memory handshake tracker states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_state_e;

    // Mult/div occupancy tracker states.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage : hazard_pkg

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy tracker: a load/decrement counter that stays busy for
// MD_LAT cycles after the mult/div leaves the E stage.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic busy_o
);

    localparam int CW = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a new op reloads the counter, otherwise BUSY counts down to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (load_i) begin
                    cnt_d   = CNT_LOAD;
                    state_d = MD_BUSY;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (load_i) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_d == CNT_ZERO) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = MD_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == MD_BUSY);

endmodule : md_busy_tracker

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use / branch
// interlocks, mult/div occupancy stalls, variable-latency memory waits with
// timeout, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              BranchD,
    input  logic              MemToRegE,
    input  logic              RegWriteE,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemWriteM,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RtM,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              MdStartE,
    input  logic              MdUseD,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              ForwardMM,
    output logic              MemErr,
    output logic [CNT_W-1:0]  StallCycles
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    // Wait count held while the final permitted wait cycle is in progress.
    localparam logic [WW-1:0]     WAIT_LAST = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0]     WAIT_ONE  = WW'(1);
    localparam logic [WW-1:0]     WAIT_ZERO = {WW{1'b0}};
    localparam logic [REG_AW-1:0] ZERO_IDX  = REG_AW'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    // A producer feeds a consumer when it writes the same non-zero register.
    function automatic logic fwd_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              we);
        return we && (src == dst) && (src != ZERO_IDX);
    endfunction

    mem_state_e       mem_state_q, mem_state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait_s;
    logic lw_stall_s;
    logic br_stall_s;
    logic md_stall_s;
    logic md_load_s;
    logic md_busy_s;

    assign MemErr      = (mem_state_q == ERR);
    assign StallCycles = stall_cnt_q;

    // Once the timeout flag is up the memory no longer holds the pipeline.
    assign mem_wait_s = MemReqM && !MemReadyM && !MemErr;
    assign lw_stall_s = MemToRegE && ((RsD == RtE) || (RtD == RtE));
    assign br_stall_s = BranchD &&
                        ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                         (MemToRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    // A mult/div caught behind a memory wait has not really left E yet.
    assign md_load_s  = MdStartE && !mem_wait_s;
    assign md_stall_s = MdUseD && (md_busy_s || md_load_s);

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (md_load_s),
        .busy_o (md_busy_s)
    );

    // Forwarding selects and prioritised stall/flush controls, all forced low in reset.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardMM = 1'b0;
        if (!rst_n) begin
            StallF = 1'b0;
        end else begin
            if (fwd_hit(RsE, WriteRegM, RegWriteM)) begin
                ForwardAE = FWD_MEM;
            end else if (fwd_hit(RsE, WriteRegW, RegWriteW)) begin
                ForwardAE = FWD_WB;
            end else begin
                ForwardAE = FWD_NONE;
            end
            if (fwd_hit(RtE, WriteRegM, RegWriteM)) begin
                ForwardBE = FWD_MEM;
            end else if (fwd_hit(RtE, WriteRegW, RegWriteW)) begin
                ForwardBE = FWD_WB;
            end else begin
                ForwardBE = FWD_NONE;
            end
            ForwardAD = fwd_hit(RsD, WriteRegM, RegWriteM);
            ForwardBD = fwd_hit(RtD, WriteRegM, RegWriteM);
            ForwardMM = fwd_hit(RtM, WriteRegW, RegWriteW) && MemWriteM;

            if (mem_wait_s) begin
                // Freeze everything up to M; E is held rather than bubbled.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (lw_stall_s || br_stall_s || md_stall_s) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                FlushE = 1'b0;
            end
        end
    end

    // Memory tracker and stall counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_state_q <= IDLE;
            wait_cnt_q  <= WAIT_ZERO;
            stall_cnt_q <= CNT_ZERO;
        end else begin
            mem_state_q <= mem_state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Memory next-state: count waited cycles, give up into sticky ERR at the limit.
    always_comb begin
        mem_state_d = mem_state_q;
        wait_cnt_d  = wait_cnt_q;
        case (mem_state_q)
            IDLE, WAIT: begin
                if (mem_wait_s) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        mem_state_d = ERR;
                        wait_cnt_d  = wait_cnt_q;
                    end else begin
                        mem_state_d = WAIT;
                        wait_cnt_d  = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    mem_state_d = IDLE;
                    wait_cnt_d  = WAIT_ZERO;
                end
            end
            ERR: begin
                mem_state_d = ERR;
                wait_cnt_d  = wait_cnt_q;
            end
            default: begin
                mem_state_d = IDLE;
                wait_cnt_d  = WAIT_ZERO;
            end
        endcase
    end

    // Stall-cycle counter: count fetch-stall cycles, stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational
// forwarding/interlock logic plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    logic BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MemWriteM;
    logic [4:0] RsD, RtD, RsE, RtE, RtM, WriteRegE, WriteRegM, WriteRegW;
    logic MdStartE, MdUseD, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, ForwardMM, MemErr;
    logic [15:0] StallCycles;

    // Second instance with a tiny counter to reach saturation quickly.
    logic d2_sf, d2_sd, d2_se, d2_sm, d2_fe, d2_fw, d2_fad, d2_fbd, d2_fmm, d2_err;
    logic [1:0] d2_fae, d2_fbe;
    logic [1:0] d2_cnt;

    int total = 0;
    int bad = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .BranchD(BranchD), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
        .MemToRegM(MemToRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteM(MemWriteM),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .RtM(RtM),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .MdStartE(MdStartE), .MdUseD(MdUseD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardMM(ForwardMM),
        .MemErr(MemErr), .StallCycles(StallCycles)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .BranchD(BranchD), .MemToRegE(MemToRegE), .RegWriteE(RegWriteE),
        .MemToRegM(MemToRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteM(MemWriteM),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .RtM(RtM),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .MdStartE(MdStartE), .MdUseD(MdUseD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(d2_sf), .StallD(d2_sd), .StallE(d2_se), .StallM(d2_sm),
        .FlushE(d2_fe), .FlushW(d2_fw),
        .ForwardAE(d2_fae), .ForwardBE(d2_fbe),
        .ForwardAD(d2_fad), .ForwardBD(d2_fbd), .ForwardMM(d2_fmm),
        .MemErr(d2_err), .StallCycles(d2_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctrl = {BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MemWriteM}
    // exp  = {StallF,StallD,StallE,StallM, FlushE,FlushW, FAE, FBE, FAD,FBD,FMM}
    typedef struct {
        logic [6:0]  ctrl;
        logic [4:0]  rsd, rtd, rse, rte, rtm, wre, wrm, wrw;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [12:0] outv();
        return {StallF, StallD, StallE, StallM, FlushE, FlushW,
                ForwardAE, ForwardBE, ForwardAD, ForwardBD, ForwardMM};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    task automatic clear_inputs();
        {BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MemWriteM} = 7'd0;
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0; RtM = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        MdStartE = 1'b0; MdUseD = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        {BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MemWriteM} = v.ctrl;
        RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte; RtM = v.rtm;
        WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    endtask

    initial begin
        int stallm_cnt;
        tbl[0]  = '{7'b0000000, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0,  5'd0,  5'd0,  5'd0,  13'b0000_00_00_00_000};
        tbl[1]  = '{7'b0000110, 5'd0, 5'd0,  5'd5, 5'd5, 5'd0,  5'd0,  5'd5,  5'd5,  13'b0000_00_10_10_000};
        tbl[2]  = '{7'b0000110, 5'd0, 5'd0,  5'd0, 5'd5, 5'd0,  5'd0,  5'd5,  5'd5,  13'b0000_00_00_10_000};
        tbl[3]  = '{7'b0000010, 5'd0, 5'd0,  5'd7, 5'd3, 5'd0,  5'd0,  5'd7,  5'd7,  13'b0000_00_01_00_000};
        tbl[4]  = '{7'b0000110, 5'd0, 5'd0,  5'd9, 5'd4, 5'd0,  5'd0,  5'd4,  5'd9,  13'b0000_00_01_10_000};
        tbl[5]  = '{7'b0000110, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0,  5'd0,  5'd0,  5'd0,  13'b0000_00_00_00_000};
        tbl[6]  = '{7'b0000100, 5'd6, 5'd11, 5'd0, 5'd0, 5'd0,  5'd0,  5'd6,  5'd0,  13'b0000_00_00_00_100};
        tbl[7]  = '{7'b0000100, 5'd2, 5'd11, 5'd0, 5'd0, 5'd0,  5'd0,  5'd11, 5'd0,  13'b0000_00_00_00_010};
        tbl[8]  = '{7'b0000011, 5'd0, 5'd0,  5'd0, 5'd0, 5'd12, 5'd0,  5'd0,  5'd12, 13'b0000_00_00_00_001};
        tbl[9]  = '{7'b0000010, 5'd0, 5'd0,  5'd0, 5'd0, 5'd12, 5'd0,  5'd0,  5'd12, 13'b0000_00_00_00_000};
        tbl[10] = '{7'b0100000, 5'd8, 5'd0,  5'd0, 5'd8, 5'd0,  5'd0,  5'd0,  5'd0,  13'b1100_10_00_00_000};
        tbl[11] = '{7'b0100000, 5'd3, 5'd8,  5'd0, 5'd8, 5'd0,  5'd0,  5'd0,  5'd0,  13'b1100_10_00_00_000};
        tbl[12] = '{7'b0100000, 5'd3, 5'd4,  5'd0, 5'd8, 5'd0,  5'd0,  5'd0,  5'd0,  13'b0000_00_00_00_000};
        tbl[13] = '{7'b1010000, 5'd13, 5'd0, 5'd0, 5'd0, 5'd0,  5'd13, 5'd0,  5'd0,  13'b1100_10_00_00_000};
        tbl[14] = '{7'b1001100, 5'd0, 5'd14, 5'd0, 5'd0, 5'd0,  5'd0,  5'd14, 5'd0,  13'b1100_10_00_00_010};
        tbl[15] = '{7'b1010000, 5'd1, 5'd2,  5'd0, 5'd0, 5'd0,  5'd13, 5'd0,  5'd0,  13'b0000_00_00_00_000};
        tbl[16] = '{7'b1000100, 5'd0, 5'd14, 5'd0, 5'd0, 5'd0,  5'd0,  5'd14, 5'd0,  13'b0000_00_00_00_010};

        // Outputs forced low while reset is held, even with hazards present.
        clear_inputs();
        rst_n = 1'b0;
        MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
        RegWriteM = 1'b1; RsE = 5'd5; WriteRegM = 5'd5;
        @(negedge clk);
        chk("rst_force", 32'(outv()), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("rst_outs", 32'(outv()), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        chk("rst_cnt", 32'(StallCycles), 32'd0);
        next_cycle();

        // Combinational forwarding / interlock table.
        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outv()), 32'(tbl[i].exp));
            next_cycle();
        end

        // Load-use: one stall cycle, counted once.
        do_reset();
        MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
        @(negedge clk);
        chk("lu_stall", 32'(outv()), 32'(13'b1100_10_00_00_000));
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("lu_clear", 32'(outv()), 32'd0);
        chk("lu_cnt", 32'(StallCycles), 32'd1);
        next_cycle();

        // Mult/div: consumer stalls MD_LAT+1 cycles, forwarding unaffected.
        do_reset();
        MdStartE = 1'b1; MdUseD = 1'b1;
        RegWriteM = 1'b1; RsE = 5'd5; WriteRegM = 5'd5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("md_stall%0d", i), 32'({StallF, StallD, FlushE}),
                (i < 5) ? 32'd7 : 32'd0);
            chk($sformatf("md_fwd%0d", i), 32'(ForwardAE), 32'd2);
            next_cycle();
            MdStartE = 1'b0;
        end

        // Memory wait of 3 cycles with a load-use hazard hidden behind it.
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
        stallm_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MemReadyM = 1'b1;
            @(negedge clk);
            if (StallM) stallm_cnt = stallm_cnt + 1;
            chk($sformatf("mw_cyc%0d", i), 32'(outv()),
                (i < 3) ? 32'(13'b1111_01_00_00_000) : 32'(13'b1100_10_00_00_000));
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("mw_stallm_cnt", 32'(stallm_cnt), 32'd3);
        chk("mw_memerr", 32'(MemErr), 32'd0);
        next_cycle();

        // Timeout: 15 wait cycles, then sticky error and the pipeline drains.
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", i), 32'(outv()),
                (i < 15) ? 32'(13'b1111_01_00_00_000) : 32'd0);
            chk($sformatf("to_err%0d", i), 32'(MemErr), (i >= 15) ? 32'd1 : 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("to_cnt", 32'(StallCycles), 32'd15);
        chk("to_sat", 32'(d2_cnt), 32'd3);
        chk("to_d2_outs", 32'({d2_sf, d2_sd, d2_se, d2_sm, d2_fe, d2_fw, d2_fae, d2_fbe,
                               d2_fad, d2_fbd, d2_fmm, d2_err}), 32'd1);
        next_cycle();
        MemReqM = 1'b0;
        @(negedge clk);
        chk("to_sticky", 32'(MemErr), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("to_rst_clear", 32'(MemErr), 32'd0);
        next_cycle();

        // Reset mid-operation with mdCnt=2 and memory in WAIT.
        do_reset();
        MdStartE = 1'b1;
        next_cycle();
        MdStartE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rm_wait", 32'(outv()), 32'(13'b1111_01_00_00_000));
        rst_n = 1'b0;
        MdUseD = 1'b1;
        #1;
        chk("rm_force", 32'(outv()), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        MemReqM = 1'b0;
        @(negedge clk);
        chk("rm_outs", 32'(outv()), 32'd0);
        chk("rm_memerr", 32'(MemErr), 32'd0);
        chk("rm_cnt", 32'(StallCycles), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rm_outs2", 32'(outv()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core, successor to the single-cycle-only hazard unit. It resolves data hazards by forwarding, and resolves load-use and decode-branch hazards by stall/flush. It adds two stall sources: a multi-cycle mult/div unit, tracked by a latency counter, and a variable-latency data memory with a ready handshake and timeout. It also provides a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_AW, 5, register-address width
- MD_LAT, 4, mult/div latency in cycles (≥1)
- MEM_TIMEOUT, 15, max wait cycles on one memory request before error (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- BranchD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MemWriteM  in  1 each  stage control bits
- RsD, RtD, RsE, RtE, RtM, WriteRegE, WriteRegM, WriteRegW  in  REG_AW each  stage register indices
- MdStartE  in  1  mult/div op occupies E
- MdUseD  in  1  D-stage instruction reads HI/LO or issues mult/div
- MemReqM  in  1  M-stage load/store active
- MemReadyM  in  1  data memory completes the request this cycle
- StallF, StallD, StallE, StallM  out  1  active-high hold of the pipeline register feeding that stage
- FlushE, FlushW  out  1  insert bubble into E / W
- ForwardAE, ForwardBE  out  2  E-operand select
- ForwardAD, ForwardBD  out  1  M→D forward for branch compare
- ForwardMM  out  1  W→M store-data forward
- MemErr  out  1  sticky memory-timeout flag
- StallCycles  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- Forwarding (combinational). Register 0 is never forwarded.
  - ForwardAE/BE: 10 when the operand equals WriteRegM with RegWriteM; otherwise 01 when it equals WriteRegW with RegWriteW; otherwise 00. M wins over W.
  - ForwardAD/BD: operand equals WriteRegM with RegWriteM.
  - ForwardMM: RtM equals WriteRegW, with RegWriteW and MemWriteM.
- lwStall = MemToRegE & (RsD==RtE | RtD==RtE).
- brStall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemToRegM & WriteRegM∈{RsD,RtD})).
- memWait = MemReqM & !MemReadyM & !MemErr.
- mdStall = MdUseD & (mdCnt≠0 | (MdStartE & !memWait)).
- Priority 1, memWait: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0. E is held, not flushed.
- Priority 2, lwStall | brStall | mdStall (no memWait): StallF=StallD=1, FlushE=1, StallE=StallM=FlushW=0.
- Otherwise all stalls and flushes are 0.
- Mult/div tracker FSM, states IDLE (mdCnt=0) and BUSY (mdCnt≠0):
  - MdStartE & !memWait loads mdCnt=MD_LAT; load overrides decrement.
  - In BUSY, mdCnt decrements by 1 every cycle, including during memWait.
  - BUSY→IDLE when mdCnt reaches 0.
- Memory FSM, states IDLE, WAIT, ERR:
  - IDLE→WAIT on memWait.
  - WAIT counts waited cycles in waitCnt; WAIT→IDLE on MemReadyM.
  - WAIT→ERR when waitCnt reaches MEM_TIMEOUT with MemReadyM still low.
  - ERR sets MemErr=1, which then masks memWait so the pipeline drains.
  - ERR exits only on reset.
- StallCycles increments each cycle StallF=1 and saturates at all-ones.

## Timing
- Reset (rst_n=0 at a rising edge): mdCnt=0, waitCnt=0, memory FSM=IDLE, MemErr=0, StallCycles=0.
- While rst_n=0, all stall, flush and forward outputs are forced to 0.
- Reset mid-operation aborts any pending mult/div or memory wait. No stall persists after the reset edge.
- All stall, flush and forward outputs are combinational from inputs and state, so they are valid in the same cycle.
- MdStartE leaves E at edge t:
  - A consumer in D during cycle t stalls in cycles t through t+MD_LAT, which is MD_LAT+1 cycles.
  - It advances into E at edge t+MD_LAT+1.
- Memory request with ready after k cycles of wait (k<MEM_TIMEOUT): StallM is high exactly k cycles.
- MemErr rises the cycle after the MEM_TIMEOUT-th wait cycle.
- Simultaneous memWait and lwStall: memWait rules apply. lwStall re-evaluates once memory completes.

## Structure
- Shared package hazard_pkg holds:
  - REG_ZERO.
  - Forward encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Memory FSM state enum {IDLE, WAIT, ERR}.
- Sub-module md_busy_tracker, parameter MD_LAT, contains the mdCnt load/decrement counter and outputs busy. All other logic lives in hazard_ctrl.

## Test plan
- Forwarding: RsE=RtE=5, WriteRegM=WriteRegW=5, both RegWrite=1 → ForwardAE=ForwardBE=10. With RsE=0 and the same writes → ForwardAE=00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle, StallCycles=1.
- Mult/div (MD_LAT=4): MdStartE in cycle t, MdUseD held from cycle t → StallD high in cycles t..t+4, low at t+5, ForwardAE unaffected.
- Memory wait: MemReqM=1 with MemReadyM low 3 cycles then high → StallF/D/E/M and FlushW high exactly 3 cycles, MemErr=0.
- Timeout (MEM_TIMEOUT=15): MemReadyM never rises → MemErr=1 after 15 wait cycles, stalls drop and stay low, and MemErr clears only after rst_n=0.
- Reset mid-op: rst_n=0 while mdCnt=2 and in WAIT → next cycle all outputs 0, and MdUseD=1 produces no stall.
